multi_master_bus: RTL and testbench

- Parametrised shared tri-state bus for `M` masters, each `N` bits wide.
- Contains a round-robin arbiter FSM that drives a registered one-hot grant, with one mandatory turnaround cycle between owners.
- Each master has a tri-state driver onto an internal bus, plus a registered receive port that captures whatever any other master drives.
- It is the successor to the two-device tri-state bus: it generalises channel count and adds ownership handshakes, fairness, turnaround and an optional hold timeout.

---
 rtl/multi_master_bus.sv | 181 ++++++++++++++++++
 tb/tb_multi_master_bus.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_master_bus.sv
// multi_master_bus: shared tri-state bus for M masters of N bits each.
// A round-robin arbiter grants one owner at a time (registered one-hot grant)
// and always inserts one idle turnaround cycle between owners. Every
// non-owner captures the bus value into its own rdata slice each busy cycle.
// Optional feature macro: BUS_TIMEOUT_EN. When it is defined, an owner is
// forced off the bus after MAX_HOLD consecutive grant cycles and timeout pulses.
module multi_master_bus #(
  parameter int N        = 8,
  parameter int M        = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [M-1:0]         req,
  input  logic [M-1:0]         done,
  input  logic [M*N-1:0]       wdata,
  output logic [M-1:0]         grant,
  output logic [M*N-1:0]       rdata,
  output logic [M-1:0]         rvalid,
  output logic [$clog2(M)-1:0] owner_id,
  output logic                 bus_busy,
  output logic                 timeout
);

  localparam int IW = $clog2(M);

  // Ownership handshake: req[i] asks for / keeps the bus. While grant[i] is
  // high, master i owns the bus; done[i] high in that cycle marks its last
  // beat, which is still driven and captured. Owner data reaches the other
  // masters' rdata one edge later, flagged by a one-cycle rvalid pulse.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_TURN  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [M-1:0]   grant_q, grant_d;
  logic [IW-1:0]  owner_q, owner_d;
  logic [IW-1:0]  ptr_q, ptr_d;
  logic [M*N-1:0] rdata_q, rdata_d;
  logic [M-1:0]   rvalid_q, rvalid_d;

  logic           win_found;
  logic [IW-1:0]  win_idx;
  logic [IW-1:0]  scan_idx;
  logic           rel;

  tri   [N-1:0]   bus_w;

`ifdef BUS_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0]  hold_q, hold_d;
  logic           timeout_q, timeout_d;
`endif

  // One tri-state driver per master; the one-hot grant enables at most one.
  for (genvar g = 0; g < M; g++) begin : g_drv
    assign bus_w = grant_q[g] ? wdata[g*N +: N] : {N{1'bz}};
  end

  // Round-robin pick: first requester scanning upward from the pointer, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int k = 0; k < M; k++) begin
      scan_idx = IW'((int'(ptr_q) + k) % M);
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Arbiter next-state: IDLE/TURN grant the winner, GRANT holds until release.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    rel     = 1'b0;
`ifdef BUS_TIMEOUT_EN
    hold_d    = hold_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      S_IDLE, S_TURN: begin
        if (win_found) begin
          state_d          = S_GRANT;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          owner_d          = win_idx;
`ifdef BUS_TIMEOUT_EN
          hold_d = '0;
`endif
        end else begin
          state_d = S_IDLE;
          grant_d = '0;
        end
      end
      S_GRANT: begin
        // done beats req: the owner's last beat still goes out this cycle.
        rel = !req[owner_q] || done[owner_q];
`ifdef BUS_TIMEOUT_EN
        hold_d = hold_q + 1'b1;
        if (!rel && (hold_q == HW'(MAX_HOLD - 1))) begin
          rel       = 1'b1;
          timeout_d = 1'b1;
        end
`endif
        if (rel) begin
          state_d = S_TURN;
          grant_d = '0;
          ptr_d   = (owner_q == IW'(M - 1)) ? '0 : owner_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Receive path: every non-owner samples the bus while someone owns it.
  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = '0;
    for (int i = 0; i < M; i++) begin
      if (bus_busy && !grant_q[i]) begin
        rdata_d[i*N +: N] = bus_w;
        rvalid_d[i]       = 1'b1;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      ptr_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

`ifdef BUS_TIMEOUT_EN
  // Hold counter and forced-release pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_max_hold;
  assign unused_max_hold = (MAX_HOLD > 0);
  assign timeout         = 1'b0;
`endif

  assign grant    = grant_q;
  assign owner_id = owner_q;
  assign rdata    = rdata_q;
  assign rvalid   = rvalid_q;
  assign bus_busy = |grant_q;

endmodule

// File: tb/tb_multi_master_bus.sv
// Testbench for multi_master_bus (M=4, N=8, MAX_HOLD=4). Directed scenario
// tasks plus a randomized run checked against an ownership-level model.
`timescale 1ns/1ps
module tb_multi_master_bus;

  localparam int N        = 8;
  localparam int M        = 4;
  localparam int MAX_HOLD = 4;

  // ---------------- clock / reset / DUT ----------------
  logic           clk = 1'b0;
  logic           rst;
  logic [M-1:0]   req;
  logic [M-1:0]   done;
  logic [M*N-1:0] wdata;
  logic [M-1:0]   grant;
  logic [M*N-1:0] rdata;
  logic [M-1:0]   rvalid;
  logic [1:0]     owner_id;
  logic           bus_busy;
  logic           timeout;

  always #5 clk = ~clk;

  multi_master_bus #(.N(N), .M(M), .MAX_HOLD(MAX_HOLD)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .done     (done),
    .wdata    (wdata),
    .grant    (grant),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .owner_id (owner_id),
    .bus_busy (bus_busy),
    .timeout  (timeout)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  // Ownership view: mdl_owner is -1 when nobody holds the bus.
  int             mdl_owner = -1;
  int             mdl_last  = 0;
  int             mdl_ptr   = 0;
  int             mdl_held  = 0;
  logic [M*N-1:0] mdl_rdata = '0;
  logic [M-1:0]   mdl_rvalid = '0;
  logic           mdl_timeout = 1'b0;

  task automatic model_edge(input logic rst_v, input logic [M-1:0] r,
                            input logic [M-1:0] d, input logic [M*N-1:0] w);
    int  win;
    bit  release_now;
    if (!rst_v) begin
      mdl_owner   = -1;
      mdl_last    = 0;
      mdl_ptr     = 0;
      mdl_held    = 0;
      mdl_rdata   = '0;
      mdl_rvalid  = '0;
      mdl_timeout = 1'b0;
      return;
    end
    mdl_rvalid  = '0;
    mdl_timeout = 1'b0;
    if (mdl_owner >= 0) begin
      for (int i = 0; i < M; i++) begin
        if (i != mdl_owner) begin
          mdl_rdata[i*N +: N] = w[mdl_owner*N +: N];
          mdl_rvalid[i]       = 1'b1;
        end
      end
      mdl_held++;
      release_now = (!r[mdl_owner] || d[mdl_owner]);
`ifdef BUS_TIMEOUT_EN
      if (!release_now && mdl_held == MAX_HOLD) begin
        release_now = 1'b1;
        mdl_timeout = 1'b1;
      end
`endif
      if (release_now) begin
        mdl_ptr   = (mdl_owner + 1) % M;
        mdl_owner = -1;
      end
    end else begin
      win = -1;
      for (int k = 0; k < M; k++)
        if (win < 0 && r[(mdl_ptr + k) % M]) win = (mdl_ptr + k) % M;
      if (win >= 0) begin
        mdl_owner = win;
        mdl_last  = win;
        mdl_held  = 0;
      end
    end
  endtask

  function automatic logic [M-1:0] exp_grant();
    logic [M-1:0] g;
    g = '0;
    if (mdl_owner >= 0) g[mdl_owner] = 1'b1;
    return g;
  endfunction

  // ---------------- driver ----------------
  // Drive inputs, take one rising edge, advance the model, sample 1ns later.
  task automatic step(input logic rst_v, input logic [M-1:0] r,
                      input logic [M-1:0] d, input logic [M*N-1:0] w);
    rst   = rst_v;
    req   = r;
    done  = d;
    wdata = w;
    @(posedge clk);
    model_edge(rst_v, r, d, w);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    step(1'b0, 4'b1111, '0, '0);
    step(1'b0, 4'b1111, '0, '0);
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b expected %b", grant, 4'b0000); end
    checks++; if (rdata !== '0) begin errors++; $display("FAIL reset_rdata: got %h expected %h", rdata, 32'h0); end
    checks++; if (rvalid !== 4'b0000) begin errors++; $display("FAIL reset_rvalid: got %b expected %b", rvalid, 4'b0000); end
    checks++; if (owner_id !== 2'd0) begin errors++; $display("FAIL reset_owner: got %0d expected 0", owner_id); end
    checks++; if (bus_busy !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL reset_busy_timeout: got %b%b expected 00", bus_busy, timeout); end
    step(1'b1, 4'b1111, '0, '0);
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL reset_release_grant: got %b expected %b", grant, 4'b0001); end
  endtask

  task automatic test_single_transfer();
    logic [M*N-1:0] w;
    w = '0;
    w[2*N +: N] = 8'hA5;
    step(1'b1, 4'b0000, '0, '0);   // master 0 drops req -> turnaround
    step(1'b1, 4'b0000, '0, '0);   // idle
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL single_idle_grant: got %b expected %b", grant, 4'b0000); end
    step(1'b1, 4'b0100, '0, '0);
    checks++; if (grant !== 4'b0100 || owner_id !== 2'd2) begin errors++; $display("FAIL single_grant: got %b/%0d expected 0100/2", grant, owner_id); end
    step(1'b1, 4'b0100, 4'b0100, w);
    checks++; if (rvalid !== 4'b1011) begin errors++; $display("FAIL single_rvalid: got %b expected %b", rvalid, 4'b1011); end
    checks++; if (rdata !== 32'hA500A5A5) begin errors++; $display("FAIL single_rdata: got %h expected %h", rdata, 32'hA500A5A5); end
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL single_turn: got %b expected %b", grant, 4'b0000); end
    step(1'b1, 4'b0000, '0, '0);
    checks++; if (grant !== 4'b0000 || rvalid !== 4'b0000 || bus_busy !== 1'b0) begin errors++; $display("FAIL single_after_turn: got grant=%b rvalid=%b busy=%b expected 0000 0000 0", grant, rvalid, bus_busy); end
  endtask

  task automatic test_round_robin();
    logic [M-1:0] exp_seq [9];
    exp_seq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                4'b0000, 4'b1000, 4'b0000, 4'b0001};
    step(1'b0, '0, '0, '0);
    for (int k = 0; k < 9; k++) begin
      step(1'b1, 4'b1111, 4'b1111, '0);
      checks++;
      if (grant !== exp_seq[k]) begin
        errors++;
        $display("FAIL rr_seq[%0d]: got %b expected %b", k, grant, exp_seq[k]);
      end
    end
  endtask

  task automatic test_wrap_skip();
    step(1'b0, '0, '0, '0);
    step(1'b1, 4'b1000, '0, '0);
    checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL wrap_owner3: got %b expected %b", grant, 4'b1000); end
    step(1'b1, 4'b0110, '0, '0);
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL wrap_turn: got %b expected %b", grant, 4'b0000); end
    step(1'b1, 4'b0110, '0, '0);
    checks++; if (grant !== 4'b0010 || owner_id !== 2'd1) begin errors++; $display("FAIL wrap_next: got %b/%0d expected 0010/1", grant, owner_id); end
  endtask

  task automatic test_reset_mid();
    logic [M*N-1:0] w;
    w = '0;
    w[1*N +: N] = 8'h3C;
    step(1'b1, 4'b0010, '0, w);
    checks++; if (rvalid !== 4'b1101 || rdata[N-1:0] !== 8'h3C) begin errors++; $display("FAIL mid_capture: got rvalid=%b rdata0=%h expected 1101 3c", rvalid, rdata[N-1:0]); end
    step(1'b0, 4'b0010, '0, w);
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL mid_grant: got %b expected %b", grant, 4'b0000); end
    checks++; if (rvalid !== 4'b0000 || rdata !== '0) begin errors++; $display("FAIL mid_rx: got rvalid=%b rdata=%h expected 0000 0", rvalid, rdata); end
    checks++; if (owner_id !== 2'd0) begin errors++; $display("FAIL mid_owner: got %0d expected 0", owner_id); end
    step(1'b1, 4'b1111, '0, '0);
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL mid_ptr_zero: got %b expected %b", grant, 4'b0001); end
  endtask

  task automatic test_timeout();
    step(1'b0, '0, '0, '0);
    step(1'b1, 4'b0011, '0, '0);
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL to_first: got %b expected %b", grant, 4'b0001); end
`ifdef BUS_TIMEOUT_EN
    for (int k = 0; k < MAX_HOLD - 1; k++) begin
      step(1'b1, 4'b0011, '0, '0);
      checks++; if (grant !== 4'b0001 || timeout !== 1'b0) begin errors++; $display("FAIL to_hold[%0d]: got %b/%b expected 0001/0", k, grant, timeout); end
    end
    step(1'b1, 4'b0011, '0, '0);
    checks++; if (grant !== 4'b0000 || timeout !== 1'b1) begin errors++; $display("FAIL to_force: got %b/%b expected 0000/1", grant, timeout); end
    step(1'b1, 4'b0011, '0, '0);
    checks++; if (grant !== 4'b0010 || timeout !== 1'b0) begin errors++; $display("FAIL to_next: got %b/%b expected 0010/0", grant, timeout); end
`else
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 4'b0011, '0, '0);
      checks++; if (grant !== 4'b0001 || timeout !== 1'b0) begin errors++; $display("FAIL to_unbounded[%0d]: got %b/%b expected 0001/0", k, grant, timeout); end
    end
`endif
  endtask

  task automatic test_random();
    logic           rst_v;
    logic [M-1:0]   r, d;
    logic [M*N-1:0] w;
    step(1'b0, '0, '0, '0);
    for (int n = 0; n < 400; n++) begin
      rst_v = ($urandom_range(0, 63) != 0);
      r     = M'($urandom);
      d     = ($urandom_range(0, 2) == 0) ? M'($urandom) : '0;
      w     = {$urandom};
      step(rst_v, r, d, w);
      checks++; if (grant !== exp_grant() || bus_busy !== (mdl_owner >= 0)) begin errors++; $display("FAIL rnd_grant@%0d: got %b expected %b", n, grant, exp_grant()); end
      checks++; if (owner_id !== 2'(mdl_last)) begin errors++; $display("FAIL rnd_owner@%0d: got %0d expected %0d", n, owner_id, mdl_last); end
      checks++; if (rvalid !== mdl_rvalid || rdata !== mdl_rdata) begin errors++; $display("FAIL rnd_rx@%0d: got %b/%h expected %b/%h", n, rvalid, rdata, mdl_rvalid, mdl_rdata); end
      checks++; if (timeout !== mdl_timeout) begin errors++; $display("FAIL rnd_timeout@%0d: got %b expected %b", n, timeout, mdl_timeout); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst   = 1'b0;
    req   = '0;
    done  = '0;
    wdata = '0;
    @(negedge clk);
    test_reset();
    test_single_transfer();
    test_round_robin();
    test_wrap_skip();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
